alu_share_arb: RTL and testbench

Arbiter/sequencer that time-shares the single combinational ALU between two requesters. Port 0 is the main execute stage; port 1 is a secondary unit, such as a multi-cycle address or iterative op unit. Each cycle it grants at most one request, drives the ALU operand/funct inputs, and captures the ALU result and flags into a response register. The response register is returned to the owning requester with a valid/ready handshake.

---
 rtl/alu_share_arb.sv | 133 +++++++++++++
 tb/tb_alu_share_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one combinational ALU between two requesters.
// Ports: req0/req1 valid/ready + operands, ALU drive/return, resp0/resp1
// valid/ready with shared resp_res/resp_flags.
// Synchronous active-low reset (rst_n).
// Macro ALU_SHARE_FIXED_PRI_EN: port 0 always wins contention (port 1 may
// starve). When undefined, contention is resolved round-robin.
module alu_share_arb #(
   parameter int DATA_W  = 32,
   parameter int FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_rs,
   input  logic [DATA_W-1:0]  req0_rt,
   input  logic [FUNCT_W-1:0] req0_funct,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_rs,
   input  logic [DATA_W-1:0]  req1_rt,
   input  logic [FUNCT_W-1:0] req1_funct,
   output logic [DATA_W-1:0]  alu_data_rs,
   output logic [DATA_W-1:0]  alu_data_rt,
   output logic [FUNCT_W-1:0] alu_funct,
   input  logic [DATA_W:0]    alu_res,
   input  logic [4:0]         alu_flags,
   output logic               resp0_valid,
   input  logic               resp0_ready,
   output logic               resp1_valid,
   input  logic               resp1_ready,
   output logic [DATA_W:0]    resp_res,
   output logic [4:0]         resp_flags
);

   logic            busy_q, busy_d;
   logic            owner_q, owner_d;
   logic            last_grant_q, last_grant_d;
   logic [DATA_W:0] res_q, res_d;
   logic [4:0]      flags_q, flags_d;

   logic grant;
   logic own_rdy;
   logic can_accept;
   logic any_valid;
   logic accept;

   // Priority choice; grant only matters when some request is valid.
`ifdef ALU_SHARE_FIXED_PRI_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant_q;

   always_comb begin
      grant = 1'b0;
      if (!req0_valid && req1_valid)
         grant = 1'b1;
   end
`else
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant_q;
      else if (req1_valid)
         grant = 1'b1;
   end
`endif

   // Owner draining this cycle frees the slot for a same-cycle refill.
   assign own_rdy    = owner_q ? resp1_ready : resp0_ready;
   assign can_accept = ~busy_q | own_rdy;

   assign req0_ready = rst_n & can_accept & req0_valid & ~grant;
   assign req1_ready = rst_n & can_accept & req1_valid & grant;
   assign accept     = req0_ready | req1_ready;

   assign any_valid = req0_valid | req1_valid;

   always_comb begin
      alu_data_rs = '0;
      alu_data_rt = '0;
      alu_funct   = '0;
      if (any_valid) begin
         if (grant) begin
            alu_data_rs = req1_rs;
            alu_data_rt = req1_rt;
            alu_funct   = req1_funct;
         end else begin
            alu_data_rs = req0_rs;
            alu_data_rt = req0_rt;
            alu_funct   = req0_funct;
         end
      end
   end

   always_comb begin
      busy_d       = busy_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      res_d        = res_q;
      flags_d      = flags_q;
      if (accept) begin
         busy_d       = 1'b1;
         owner_d      = req1_ready;
         last_grant_d = req1_ready;
         res_d        = alu_res;
         flags_d      = alu_flags;
      end else if (busy_q && own_rdy) begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         res_q        <= '0;
         flags_q      <= '0;
      end else begin
         busy_q       <= busy_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         res_q        <= res_d;
         flags_q      <= flags_d;
      end
   end

   assign resp0_valid = rst_n & busy_q & ~owner_q;
   assign resp1_valid = rst_n & busy_q & owner_q;
   assign resp_res    = res_q;
   assign resp_flags  = flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed scoreboard bench for alu_share_arb.
// Contains a small behavioural ALU driving alu_res/alu_flags.
module tb_alu_share_arb;

   localparam logic [5:0] FN_LSL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;

   // {negzero, ovf, neg, true, zero}
   localparam logic [4:0] F_POS  = 5'b00010;
   localparam logic [4:0] F_ZERO = 5'b10001;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_rs, req0_rt;
   logic [5:0]  req0_funct;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_rs, req1_rt;
   logic [5:0]  req1_funct;
   logic [31:0] alu_data_rs, alu_data_rt;
   logic [5:0]  alu_funct;
   logic [32:0] alu_res;
   logic [4:0]  alu_flags;
   logic        resp0_valid, resp0_ready;
   logic        resp1_valid, resp1_ready;
   logic [32:0] resp_res;
   logic [4:0]  resp_flags;

   typedef struct {
      logic        port;
      logic [32:0] res;
      logic [4:0]  flg;
   } exp_t;

   exp_t sb[$];
   exp_t exp0, exp1;
   int total = 0;
   int bad = 0;

   alu_share_arb dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_rs     (req0_rs),
      .req0_rt     (req0_rt),
      .req0_funct  (req0_funct),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_rs     (req1_rs),
      .req1_rt     (req1_rt),
      .req1_funct  (req1_funct),
      .alu_data_rs (alu_data_rs),
      .alu_data_rt (alu_data_rt),
      .alu_funct   (alu_funct),
      .alu_res     (alu_res),
      .alu_flags   (alu_flags),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_res    (resp_res),
      .resp_flags  (resp_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU.
   logic ovf;
   always_comb begin
      alu_res = '0;
      ovf     = 1'b0;
      case (alu_funct)
         FN_ADD: begin
            alu_res = {1'b0, alu_data_rs} + {1'b0, alu_data_rt};
            ovf = (alu_data_rs[31] == alu_data_rt[31]) &&
                  (alu_res[31] != alu_data_rs[31]);
         end
         FN_SUB: begin
            alu_res = {1'b0, alu_data_rs} - {1'b0, alu_data_rt};
            ovf = (alu_data_rs[31] != alu_data_rt[31]) &&
                  (alu_res[31] != alu_data_rs[31]);
         end
         FN_AND: alu_res = {1'b0, alu_data_rs & alu_data_rt};
         FN_OR:  alu_res = {1'b0, alu_data_rs | alu_data_rt};
         FN_LSL: alu_res = {1'b0, alu_data_rs << alu_data_rt[4:0]};
         default: alu_res = '0;
      endcase
      alu_flags[0] = (alu_res[31:0] == 32'd0);
      alu_flags[1] = (alu_res[31:0] != 32'd0);
      alu_flags[2] = alu_res[31];
      alu_flags[3] = ovf;
      alu_flags[4] = alu_res[31] | (alu_res[31:0] == 32'd0);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set0(input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [32:0] r,
                       input logic [4:0] f);
      req0_funct = fn;
      req0_rs    = rs;
      req0_rt    = rt;
      exp0.port  = 1'b0;
      exp0.res   = r;
      exp0.flg   = f;
   endtask

   task automatic set1(input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [32:0] r,
                       input logic [4:0] f);
      req1_funct = fn;
      req1_rs    = rs;
      req1_rt    = rt;
      exp1.port  = 1'b1;
      exp1.res   = r;
      exp1.flg   = f;
   endtask

   // Issue tracker: push the hand-computed expectation on each accept.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (req0_valid && req0_ready === 1'b1) sb.push_back(exp0);
         if (req1_valid && req1_ready === 1'b1) sb.push_back(exp1);
      end
   end

   // Monitor: compare on every response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (resp0_valid === 1'b1 && resp1_valid === 1'b1)
            chk("resp_both_valid", 1, 0);
         if ((resp0_valid === 1'b1 && resp0_ready) ||
             (resp1_valid === 1'b1 && resp1_ready)) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("mon_port", {63'd0, resp1_valid}, {63'd0, e.port});
               chk("mon_res", {31'd0, resp_res}, {31'd0, e.res});
               chk("mon_flags", {59'd0, resp_flags}, {59'd0, e.flg});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e;
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      set0(FN_ADD, 32'd5, 32'd7, 33'd12, F_POS);
      set1(FN_OR, 32'd0, 32'd0, 33'd0, F_ZERO);
      req0_valid = 1'b1;
      repeat (2) step();
      smp();
      chk("rst_req0_ready", {63'd0, req0_ready}, 0);
      chk("rst_req1_ready", {63'd0, req1_ready}, 0);
      chk("rst_resp0_valid", {63'd0, resp0_valid}, 0);
      chk("rst_resp1_valid", {63'd0, resp1_valid}, 0);
      chk("rst_res", {31'd0, resp_res}, 0);
      chk("rst_flags", {59'd0, resp_flags}, 0);
      step();
      rst_n = 1'b1;
      smp();
      chk("single_ready", {63'd0, req0_ready}, 1);
      step();
      req0_valid = 1'b0;
      smp();
      chk("single_valid", {63'd0, resp0_valid}, 1);
      chk("single_res", {31'd0, resp_res}, 64'd12);
      chk("single_zt", {62'd0, resp_flags[1:0]}, 64'd2);
      step();

      // Contention
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      set0(FN_AND, 32'hF0, 32'h3C, 33'h30, F_POS);
      set1(FN_OR, 32'hF0, 32'h0F, 33'hFF, F_POS);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         smp();
`ifdef ALU_SHARE_FIXED_PRI_EN
         e = 1'b0;
`else
         e = (i % 2) == 1;
`endif
         chk("cont_ready0", {63'd0, req0_ready}, {63'd0, ~e});
         chk("cont_ready1", {63'd0, req1_ready}, {63'd0, e});
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      smp();
      step();

      // Back-pressure
      resp1_ready = 1'b0;
      set1(FN_SUB, 32'd3, 32'd3, 33'd0, F_ZERO);
      req1_valid = 1'b1;
      smp();
      chk("bp_accept1", {63'd0, req1_ready}, 1);
      step();
      set0(FN_ADD, 32'd5, 32'd7, 33'd12, F_POS);
      set1(FN_OR, 32'hF0, 32'h0F, 33'hFF, F_POS);
      req0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("bp_valid1", {63'd0, resp1_valid}, 1);
         chk("bp_res", {31'd0, resp_res}, 0);
         chk("bp_flags", {59'd0, resp_flags}, {59'd0, F_ZERO});
         chk("bp_ready0", {63'd0, req0_ready}, 0);
         chk("bp_ready1", {63'd0, req1_ready}, 0);
         step();
      end
      resp1_ready = 1'b1;
      smp();
      chk("bp_rel_ready0", {63'd0, req0_ready}, 1);
      chk("bp_rel_ready1", {63'd0, req1_ready}, 0);
      step();
      req0_valid = 1'b0;
      smp();
      chk("bp_next_ready1", {63'd0, req1_ready}, 1);
      step();
      req1_valid = 1'b0;
      smp();
      step();

      // Throughput
      for (int i = 1; i <= 8; i++) begin
         set0(FN_LSL, 32'(i), 32'd1, 33'(2 * i), F_POS);
         req0_valid = 1'b1;
         smp();
         chk("thr_ready", {63'd0, req0_ready}, 1);
         if (i > 1) chk("thr_valid", {63'd0, resp0_valid}, 1);
         step();
      end
      req0_valid = 1'b0;
      smp();
      chk("thr_last_valid", {63'd0, resp0_valid}, 1);
      step();

      // Carry capture, held while pending
      resp0_ready = 1'b0;
      set0(FN_ADD, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000, F_ZERO);
      req0_valid = 1'b1;
      smp();
      chk("cy_ready", {63'd0, req0_ready}, 1);
      step();
      req0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("cy_valid", {63'd0, resp0_valid}, 1);
         chk("cy_res", {31'd0, resp_res}, 64'h1_0000_0000);
         chk("cy_flags", {59'd0, resp_flags}, {59'd0, F_ZERO});
         step();
      end

      // Reset mid-operation discards the pending response
      rst_n = 1'b0;
      smp();
      chk("mid_rst_valid", {63'd0, resp0_valid}, 0);
      step();
      rst_n = 1'b1;
      resp0_ready = 1'b1;
      sb.delete();
      set0(FN_AND, 32'hF0, 32'h3C, 33'h30, F_POS);
      set1(FN_OR, 32'hF0, 32'h0F, 33'hFF, F_POS);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      smp();
      chk("post_rst_valid", {63'd0, resp0_valid}, 0);
      chk("post_rst_ready0", {63'd0, req0_ready}, 1);
      chk("post_rst_ready1", {63'd0, req1_ready}, 0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      smp();
      step();
      smp();
      chk("sb_empty", 64'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
